// File: rtl/grass_scroll_render_if.sv
// rtl/grass_scroll_render_if.sv - scan-position, sprite-ROM and pixel signals of grass_scroll_render
interface grass_scroll_render_if;
    logic       de;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       frame_tick;
    logic       run;
    logic [8:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] pix;
    logic       pix_valid;
    logic [4:0] scroll_offset;

    modport master (
        output de, hcnt, vcnt, frame_tick, run, rom_data,
        input  rom_addr, pix, pix_valid, scroll_offset
    );

    modport slave (
        input  de, hcnt, vcnt, frame_tick, run, rom_data,
        output rom_addr, pix, pix_valid, scroll_offset
    );
endinterface

// File: rtl/grass_scroll_render.sv
// rtl/grass_scroll_render.sv - tiles and scrolls the grass sprite across a screen band, 3-clock pixel pipeline
// GRASS_SCROLL_EN enables the per-frame scroll offset; without it the grass is static.
module grass_scroll_render #(
    parameter int TILE_W   = 20,
    parameter int TILE_H   = 20,
    parameter int GRASS_Y0 = 460,
    parameter int SPEED    = 1
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    grass_scroll_render_if.slave bus
);
    localparam logic [9:0] Y_FIRST  = 10'(GRASS_Y0);
    localparam logic [9:0] Y_END    = 10'(GRASS_Y0 + TILE_H);
    localparam logic [4:0] COL_LAST = 5'(TILE_W - 1);
    localparam logic [8:0] ROW_STEP = 9'(TILE_W);

    logic [4:0] offset;

`ifdef GRASS_SCROLL_EN
    logic [5:0] off_sum;

    // SPEED < TILE_W, so one conditional subtract is a full modulo
    always_comb begin
        off_sum = {1'b0, offset} + 6'(SPEED);
        if (off_sum >= 6'(TILE_W)) begin
            off_sum = off_sum - 6'(TILE_W);
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            offset <= 5'd0;
        end else if (bus.frame_tick && bus.run) begin
            offset <= off_sum[4:0];
        end
    end
`else
    assign offset = 5'd0;
`endif

    logic       row_in;
    logic       band;
    logic [4:0] col;
    logic [4:0] col_n;
    logic [8:0] row_base;
    logic [8:0] base_n;
    logic [9:0] vcnt_q;
    logic [2:0] vld;
    logic [8:0] addr_r;
    logic [7:0] pix_r;
    logic       pix_valid_r;

    assign row_in = (bus.vcnt >= Y_FIRST) && (bus.vcnt < Y_END);
    assign band   = bus.de && row_in;

    // The column counter loading at hcnt==0 is the line latch: a mid-line
    // offset change cannot reach it until the next line start.
    always_comb begin
        col_n = (col == COL_LAST) ? 5'd0 : col + 5'd1;
        if (bus.hcnt == 10'd0) begin
            col_n = offset;
        end
        base_n = row_base;
        if (bus.vcnt == Y_FIRST) begin
            base_n = 9'd0;
        end else if (row_in && (bus.vcnt != vcnt_q)) begin
            base_n = row_base + ROW_STEP;
        end
    end

    // vld[0]: sampled, vld[1]: address out, vld[2]: ROM byte returning
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            col         <= 5'd0;
            row_base    <= 9'd0;
            vcnt_q      <= 10'd0;
            vld         <= 3'b000;
            addr_r      <= 9'd0;
            pix_r       <= 8'h00;
            pix_valid_r <= 1'b0;
        end else begin
            col         <= col_n;
            row_base    <= base_n;
            vcnt_q      <= bus.vcnt;
            vld         <= {vld[1:0], band};
            addr_r      <= vld[0] ? (row_base + {4'd0, col}) : 9'd0;
            pix_r       <= vld[2] ? bus.rom_data : 8'h00;
            pix_valid_r <= vld[2];
        end
    end

    assign bus.rom_addr      = addr_r;
    assign bus.pix           = pix_r;
    assign bus.pix_valid     = pix_valid_r;
    assign bus.scroll_offset = offset;
endmodule

// File: tb/tb_grass_scroll_render.sv
// tb/tb_grass_scroll_render.sv - directed bench for grass_scroll_render
module tb_grass_scroll_render;
`ifdef GRASS_SCROLL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clka = 1'b0;
    logic rsta_n;
    always #5 clka = ~clka;

    grass_scroll_render_if bus ();

    grass_scroll_render dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus)
    );

    function automatic logic [7:0] rom_f(input logic [8:0] a);
        return a[7:0] ^ 8'hA5 ^ {a[8], 7'd0};
    endfunction

    always @(posedge clka) bus.rom_data <= rom_f(bus.rom_addr);

    int n_vec = 0;
    int n_err = 0;
    int h1, h2, h3, h4;
    int off_exp;
    int line_off;

    function automatic int nxt(input int o);
        if (EN) return (o + 1 >= 20) ? o + 1 - 20 : o + 1;
        return 0;
    endfunction

    function automatic int col_addr(input int row, input int h, input int off);
        return row * 20 + (h + off) % 20;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input int h, input int v, input logic ft,
                         input logic rn, input int ea);
        bus.de         = d;
        bus.hcnt       = 10'(h);
        bus.vcnt       = 10'(v);
        bus.frame_tick = ft;
        bus.run        = rn;
        @(posedge clka);
        #1;
        h4 = h3; h3 = h2; h2 = h1; h1 = ea;
        check($sformatf("rom_addr v%0d h%0d", v, h), 32'(bus.rom_addr),
              (h2 < 0) ? 32'd0 : 32'(h2));
        check($sformatf("pix_valid v%0d h%0d", v, h), 32'(bus.pix_valid),
              (h4 >= 0) ? 32'd1 : 32'd0);
        check($sformatf("pix v%0d h%0d", v, h), 32'(bus.pix),
              (h4 < 0) ? 32'd0 : 32'(rom_f(9'(h4))));
    endtask

    task automatic check_off(input string tag);
        check(tag, 32'(bus.scroll_offset), 32'(off_exp));
    endtask

    initial begin
        rsta_n         = 1'b0;
        bus.de         = 1'b0;
        bus.hcnt       = 10'd0;
        bus.vcnt       = 10'd0;
        bus.frame_tick = 1'b0;
        bus.run        = 1'b0;
        h1 = -1; h2 = -1; h3 = -1; h4 = -1;
        off_exp = 0;

        repeat (2) @(posedge clka);
        #1;
        check("reset rom_addr", 32'(bus.rom_addr), 32'd0);
        check("reset pix", 32'(bus.pix), 32'd0);
        check("reset pix_valid", 32'(bus.pix_valid), 32'd0);
        check_off("reset scroll_offset");
        rsta_n = 1'b1;

        // first band row, offset 0, with a de-low gap the column keeps counting through
        for (int h = 0; h < 25; h++) begin
            if (h >= 8 && h <= 10) drive(1'b0, h, 460, 1'b0, 1'b0, -1);
            else drive(1'b1, h, 460, 1'b0, 1'b0, col_addr(0, h, 0));
        end
        for (int h = 0; h < 4; h++) drive(1'b1, h, 500, 1'b0, 1'b0, -1);

        // ticks ignored while not running
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 700, 500, 1'b1, 1'b0, -1);
            check_off("tick run=0");
        end

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 700, 500, 1'b1, 1'b1, -1);
            off_exp = nxt(off_exp);
            check_off("tick run=1");
        end

        // walk the band: mid-line tick on 465, tick coinciding with hcnt 0 on 466
        for (int v = 459; v <= 480; v++) begin
            int  nh;
            bit  inb;
            logic ft;
            line_off = off_exp;
            nh  = (v == 465) ? 104 : (v == 479) ? 20 : (v == 459 || v == 480) ? 3 : 2;
            inb = (v >= 460) && (v < 480) && (v != 470);
            for (int h = 0; h < nh; h++) begin
                ft = ((v == 465) && (h == 100)) || ((v == 466) && (h == 0));
                drive((v != 470), h, v, ft, 1'b1, inb ? col_addr(v - 460, h, line_off) : -1);
                if (ft) begin
                    off_exp = nxt(off_exp);
                    check_off("tick in band");
                end
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 900, 500, 1'b0, 1'b1, -1);

        // enough ticks to pass through the TILE_W-1 -> 0 wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 700, 500, 1'b1, 1'b1, -1);
            off_exp = nxt(off_exp);
            check_off("tick wrap");
        end

        // asynchronous reset in the middle of a band line
        line_off = off_exp;
        for (int h = 0; h < 6; h++) drive(1'b1, h, 460, 1'b0, 1'b1, col_addr(0, h, line_off));
        #2;
        rsta_n = 1'b0;
        #1;
        off_exp = 0;
        check("midreset pix_valid", 32'(bus.pix_valid), 32'd0);
        check("midreset pix", 32'(bus.pix), 32'd0);
        check("midreset rom_addr", 32'(bus.rom_addr), 32'd0);
        check_off("midreset scroll_offset");
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
        h1 = -1; h2 = -1; h3 = -1; h4 = -1;

        for (int h = 0; h < 8; h++) drive(1'b1, h, 460, 1'b0, 1'b0, col_addr(0, h, 0));
        for (int i = 0; i < 3; i++) drive(1'b0, 900, 500, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
